mux_sweep_checker: RTL and testbench
====================================

// Module: mux_sweep_checker
// PURPOSE
//  Self-running stimulus and compare stage for the 4:1 mux implementations.
//  Sweeps all 64 combinations of {s1,s0,a,b,c,d} into two mux instances under test.
//  Waits a programmable settle time for gate-level delays, then checks both outputs
//  against a golden 4:1 select. Reports per-instance mismatch counts and the first failing vector.
// PARAMETERS
//  SETTLE_CYCLES  4  clocks a vector is held before its outputs are sampled (>=1)
//  CNT_W          8  width of each mismatch counter (saturating)
// PORTS
//  clk            in   1      system clock, rising edge
//  rst            in   1      asynchronous, active-high reset
//  start          in   1      begin a sweep; honoured only in IDLE or DONE
//  s0, s1         out  1      select lines to both muxes under test
//  a, b, c, d     out  1      data lines to both muxes under test
//  mux1_out       in   1      output of mux instance 1
//  mux2_out       in   1      output of mux instance 2
//  busy           out  1      high in SETTLE/SAMPLE
//  done           out  1      high in DONE; held until start or rst
//  mis1_cnt       out  CNT_W  mux1 mismatches this sweep
//  mis2_cnt       out  CNT_W  mux2 mismatches this sweep
//  fail_valid     out  1      a mismatch has been seen this sweep
//  fail_vec       out  6      first failing vector {s1,s0,a,b,c,d}
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, vec=0, settle_cnt=0.
//   All outputs 0, including s0..d, busy, done, counters, fail_valid and fail_vec.
//  vec[5:0] drives {s1,s0,a,b,c,d} directly, registered with no glitch logic.
//  Golden model: {s1,s0} = 00->a, 01->b, 10->c, 11->d.
//  FSM:
//   IDLE:    start=1 -> SETTLE; vec=0, settle_cnt=0; clear counters, fail_valid, fail_vec.
//   SETTLE:  settle_cnt++ each clock; at settle_cnt==SETTLE_CYCLES-1 -> SAMPLE.
//   SAMPLE:  on the exit edge, compare mux1_out and mux2_out against the golden bit.
//            A 4-state compare (!==) is used, so X or Z on an output counts as a mismatch.
//            Increment each failing instance's counter; counters saturate at 2^CNT_W-1.
//            If any mismatch and fail_valid==0: fail_vec=vec, fail_valid=1.
//            If vec==63 -> DONE; else vec++, settle_cnt=0 -> SETTLE.
//   DONE:    done=1; vec, counters and fail_vec hold. start=1 -> as IDLE start (clears all).
//  start in SETTLE/SAMPLE is ignored; a sweep is never restarted mid-run.
//  Latency: each vector takes SETTLE_CYCLES+1 clocks.
//   done rises 64*(SETTLE_CYCLES+1) edges after the edge that samples start (320 at default).
//  Reset mid-sweep returns to IDLE immediately; the partial results are discarded.
//  mux outputs are sampled only in SAMPLE; activity during SETTLE is ignored.
// STRUCTURE
//  Shared package mux_test_pkg:
//   state encoding localparams IDLE/SETTLE/SAMPLE/DONE;
//   VEC_W=6, VEC_LAST=63;
//   function golden_mux4(sel[1:0], a, b, c, d).
//  One sub-module, sat_counter (CNT_W; inc, clr), instantiated twice for mis1/mis2.
//  Everything else (FSM, settle counter, vec register) sits in this module.
// TESTING
//  1 Both ports driven by correct 4:1 muxes, start pulse:
//    -> done after 320 clks, mis1=mis2=0, fail_valid=0.
//  2 mux2_out tied 0, mux1 correct:
//    -> mis1=0, mis2=32, fail_valid=1, fail_vec=6'd8 (s=00,a=1).
//  3 CNT_W=2 with mux1_out tied 1:
//    -> mis1 saturates at 3, mis2=0, done still asserted at 320.
//  4 mux1_out driven X, mux2 correct:
//    -> mis1=64 with CNT_W=8, fail_vec=0.
//  5 start re-pulsed at clk 100 mid-sweep:
//    -> ignored, done at 320; start in DONE -> counters clear, new sweep.
//  6 rst asserted at clk 150:
//    -> all outputs 0 in the same cycle, state IDLE; a later start gives a clean sweep.

Source files
------------

// File: rtl/mux_test_pkg.sv
// Shared definitions for the 4:1 mux sweep checker: FSM states, vector
// geometry and the golden select used to judge each mux under test.
package mux_test_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int              VEC_W    = 6;
   localparam logic [VEC_W-1:0] VEC_LAST = 6'd63;

   function automatic logic golden_mux4(input logic [1:0] sel,
                                        input logic a, input logic b,
                                        input logic c, input logic d);
      return sel[1] ? (sel[0] ? d : c) : (sel[0] ? b : a);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones,
// synchronous clear for the start of each sweep.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
         count_reg <= count_reg + CNT_W'(1);
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/mux_sweep_checker.sv
// Drives all 64 {s1,s0,a,b,c,d} vectors into two muxes under test, waits a
// settle time per vector, then scores both outputs against the golden select.
module mux_sweep_checker
   import mux_test_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             s0,
   output logic             s1,
   output logic             a,
   output logic             b,
   output logic             c,
   output logic             d,
   input  logic             mux1_out,
   input  logic             mux2_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] mis1_cnt,
   output logic [CNT_W-1:0] mis2_cnt,
   output logic             fail_valid,
   output logic [5:0]       fail_vec
);

   localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

   state_t             state_reg;
   logic [VEC_W-1:0]   vec_reg;
   logic [SETTLE_W-1:0] settle_cnt_reg;
   logic               busy_reg;
   logic               done_reg;
   logic               fail_valid_reg;
   logic [VEC_W-1:0]   fail_vec_reg;

   logic               golden_bit;
   logic               sampling;
   logic               sweep_start;
   logic [1:0]         miss;
   logic [CNT_W-1:0]   mis_cnt [2];

   assign golden_bit  = golden_mux4(vec_reg[5:4], vec_reg[3], vec_reg[2],
                                    vec_reg[1], vec_reg[0]);
   assign sampling    = (state_reg == SAMPLE);
   assign sweep_start = start && ((state_reg == IDLE) || (state_reg == DONE));

   // 4-state compare so an X or Z from a gate-level model scores as a miss.
   assign miss[0] = sampling && (mux1_out !== golden_bit);
   assign miss[1] = sampling && (mux2_out !== golden_bit);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_mis
         sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr   (sweep_start),
            .inc   (miss[gi]),
            .count (mis_cnt[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         vec_reg        <= '0;
         settle_cnt_reg <= '0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         fail_valid_reg <= 1'b0;
         fail_vec_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               if (start) begin
                  state_reg      <= SETTLE;
                  vec_reg        <= '0;
                  settle_cnt_reg <= '0;
                  busy_reg       <= 1'b1;
                  done_reg       <= 1'b0;
                  fail_valid_reg <= 1'b0;
                  fail_vec_reg   <= '0;
               end
            end
            SETTLE: begin
               settle_cnt_reg <= settle_cnt_reg + SETTLE_W'(1);
               if (settle_cnt_reg == SETTLE_LAST) begin
                  state_reg <= SAMPLE;
               end
            end
            SAMPLE: begin
               if ((|miss) && !fail_valid_reg) begin
                  fail_vec_reg   <= vec_reg;
                  fail_valid_reg <= 1'b1;
               end
               if (vec_reg == VEC_LAST) begin
                  state_reg <= DONE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end else begin
                  vec_reg        <= vec_reg + VEC_W'(1);
                  settle_cnt_reg <= '0;
                  state_reg      <= SETTLE;
               end
            end
         endcase
      end
   end

   assign {s1, s0, a, b, c, d} = vec_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;
   assign fail_valid = fail_valid_reg;
   assign fail_vec   = fail_vec_reg;
   assign mis1_cnt   = mis_cnt[0];
   assign mis2_cnt   = mis_cnt[1];

endmodule

// File: tb/tb_mux_sweep_checker.sv
// Bench for mux_sweep_checker: table-driven mux responses (correct, stuck,
// X, random faults, settle glitches) scored against a vector-level model.
module tb_mux_sweep_checker;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic start = 1'b0;

   logic       s0, s1, a, b, c, d, mux1_out, mux2_out, busy, done, fail_valid;
   logic [7:0] mis1_cnt, mis2_cnt;
   logic [5:0] fail_vec;

   logic       t_s0, t_s1, t_a, t_b, t_c, t_d, t_mux1, t_mux2, t_busy, t_done, t_fv;
   logic [1:0] t_mis1, t_mis2;
   logic [5:0] t_fvec;

   logic       resp1 [64];
   logic       resp2 [64];
   logic       glitch_en = 1'b0;
   logic [5:0] vec_now, vec_q, t_vec;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Golden mux as bit arithmetic: select k picks data bit (3-k) of the vector.
   function automatic logic ref_out(input logic [5:0] v);
      int sel;
      sel = int'(v[5:4]);
      return v[3 - sel];
   endfunction

   assign vec_now = {s1, s0, a, b, c, d};
   assign t_vec   = {t_s1, t_s0, t_a, t_b, t_c, t_d};
   always @(posedge clk) vec_q <= vec_now;

   // Optional one-cycle wrong answer right after each vector change.
   assign mux1_out = (glitch_en && (vec_now != vec_q)) ? ~resp1[vec_now] : resp1[vec_now];
   assign mux2_out = (glitch_en && (vec_now != vec_q)) ? ~resp2[vec_now] : resp2[vec_now];
   assign t_mux1   = 1'b1;
   assign t_mux2   = ref_out(t_vec);

   mux_sweep_checker #(.SETTLE_CYCLES(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start),
      .s0(s0), .s1(s1), .a(a), .b(b), .c(c), .d(d),
      .mux1_out(mux1_out), .mux2_out(mux2_out),
      .busy(busy), .done(done), .mis1_cnt(mis1_cnt), .mis2_cnt(mis2_cnt),
      .fail_valid(fail_valid), .fail_vec(fail_vec)
   );

   mux_sweep_checker #(.SETTLE_CYCLES(4), .CNT_W(2)) dut_narrow (
      .clk(clk), .rst(rst), .start(start),
      .s0(t_s0), .s1(t_s1), .a(t_a), .b(t_b), .c(t_c), .d(t_d),
      .mux1_out(t_mux1), .mux2_out(t_mux2),
      .busy(t_busy), .done(t_done), .mis1_cnt(t_mis1), .mis2_cnt(t_mis2),
      .fail_valid(t_fv), .fail_vec(t_fvec)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_golden();
      for (int v = 0; v < 64; v++) begin
         resp1[v] = ref_out(6'(v));
         resp2[v] = ref_out(6'(v));
      end
   endtask

   task automatic set_random(input int odds);
      for (int v = 0; v < 64; v++) begin
         resp1[v] = ref_out(6'(v)) ^ ($urandom_range(0, odds) == 0);
         resp2[v] = ref_out(6'(v)) ^ ($urandom_range(0, odds) == 0);
      end
   endtask

   // One full sweep; restart_at >= 0 re-pulses start at that edge count.
   task automatic run_sweep(input string tag, input int restart_at);
      int e1, e2, ef, n;
      logic m1, m2;
      e1 = 0; e2 = 0; ef = -1;
      for (int v = 0; v < 64; v++) begin
         m1 = (resp1[v] !== ref_out(6'(v)));
         m2 = (resp2[v] !== ref_out(6'(v)));
         if (m1) e1++;
         if (m2) e2++;
         if ((m1 || m2) && (ef < 0)) ef = v;
      end
      if (e1 > 255) e1 = 255;
      if (e2 > 255) e2 = 255;

      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check({tag, "_start_clear"}, {busy, done, fail_valid, mis1_cnt, mis2_cnt, vec_now},
            {1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 6'd0});
      n = 0;
      while (!done && n < 400) begin
         @(posedge clk);
         #1;
         n++;
         if (n == restart_at - 1) start = 1'b1;
         if (n == restart_at) start = 1'b0;
      end
      check({tag, "_latency"}, n, 320);
      check({tag, "_mis1"}, mis1_cnt, e1);
      check({tag, "_mis2"}, mis2_cnt, e2);
      check({tag, "_fail_valid"}, fail_valid, (ef >= 0));
      check({tag, "_fail_vec"}, fail_vec, (ef >= 0) ? ef : 0);
      check({tag, "_hold"}, {busy, vec_now}, {1'b0, 6'd63});
      check({tag, "_narrow"}, {t_done, t_busy, t_mis1, t_mis2, t_fv, t_fvec},
            {1'b1, 1'b0, 2'd3, 2'd0, 1'b1, 6'd0});
      $display("sweep %s: latency=%0d mis1=%0d mis2=%0d fail_valid=%0b fail_vec=%0d",
               tag, n, mis1_cnt, mis2_cnt, fail_valid, fail_vec);
   endtask

   initial begin
      set_golden();
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {vec_now, busy, done, fail_valid, fail_vec, mis1_cnt, mis2_cnt}, 32'd0);
      check("reset_narrow", {t_vec, t_busy, t_done, t_fv, t_fvec, t_mis1, t_mis2}, 32'd0);
      @(negedge clk) rst = 1'b0;
      repeat (5) @(posedge clk);
      #1 check("idle_no_start", {busy, done, vec_now}, 8'd0);

      run_sweep("golden", -1);

      for (int v = 0; v < 64; v++) resp2[v] = 1'b0;
      run_sweep("mux2_stuck0", -1);

      set_golden();
      for (int v = 0; v < 64; v++) resp1[v] = 1'bx;
      run_sweep("mux1_x", -1);

      set_random(3);
      run_sweep("random_a", -1);
      set_random(1);
      run_sweep("random_restart", 100);
      set_random(5);
      glitch_en = 1'b1;
      run_sweep("random_glitch", -1);
      glitch_en = 1'b0;

      // Reset in the middle of a sweep must clear everything asynchronously.
      set_random(2);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (150) @(posedge clk);
      #2 rst = 1'b1;
      #1 check("midsweep_reset", {vec_now, busy, done, fail_valid, fail_vec, mis1_cnt, mis2_cnt}, 32'd0);
      repeat (4) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      repeat (6) @(posedge clk);
      #1 check("post_reset_idle", {busy, done, vec_now, mis1_cnt, mis2_cnt}, 24'd0);
      run_sweep("after_reset", -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
